// File: rtl/cmd_decoder_pkg.sv
// Shared constants and types for the command decoder: frame field codes,
// status values, ack header bytes and the control FSM state enum.
package cmd_decoder_pkg;

  localparam int unsigned FrameLen  = 48;
  localparam logic [5:0]  FrameLast = 6'(FrameLen - 1);
  localparam logic [5:0]  FrameFull = 6'(FrameLen);

  // Received bytes 6..35 are buffered; everything the ack echoes lives there.
  localparam int unsigned BufBase = 6;
  localparam int unsigned BufLen  = 30;

  localparam logic [7:0] ClassF = 8'h46;
  localparam logic [7:0] ClassC = 8'h43;
  localparam logic [7:0] OpWr   = 8'h57;
  localparam logic [7:0] OpRd   = 8'h52;

  localparam logic [7:0] StatusOk  = 8'h00;
  localparam logic [7:0] StatusErr = 8'hEE;

  localparam logic [7:0] AckLenHi = 8'h00;
  localparam logic [7:0] AckLenLo = 8'h22;
  localparam logic [7:0] AckType  = 8'h01;

  localparam logic [3:0] RegIdxLed = 4'd0;
  localparam logic [3:0] RegIdxDip = 4'd1;

  typedef enum logic [2:0] {
    StRx,
    StCheck,
    StExec,
    StTx,
    StDrain
  } state_e;

endpackage

// File: rtl/cmd_regbank.sv
// Two 16 x 32-bit register banks (F and C). F[1] is the read-only DIP switch
// view and F[0][7:0] drives the LEDs.
module cmd_regbank
  import cmd_decoder_pkg::*;
(
  input  logic        gtx_tclk_i,
  input  logic        gtx_tresetn_i,
  input  logic        wr_en_i,
  input  logic        bank_c_i,
  input  logic [3:0]  idx_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  input  logic [7:0]  gpio_dip_sw_i,
  output logic [7:0]  gpio_led_o
);

  logic [31:0] bank_f_q [16];
  logic [31:0] bank_c_q [16];

  always_ff @(posedge gtx_tclk_i or posedge gtx_tresetn_i) begin
    if (gtx_tresetn_i) begin
      for (int i = 0; i < 16; i++) begin
        bank_f_q[i] <= '0;
        bank_c_q[i] <= '0;
      end
    end else if (wr_en_i) begin
      if (bank_c_i) begin
        bank_c_q[idx_i] <= wdata_i;
      end else if (idx_i != RegIdxDip) begin
        bank_f_q[idx_i] <= wdata_i;
      end
    end
  end

  always_comb begin
    rdata_o = bank_c_i ? bank_c_q[idx_i] : bank_f_q[idx_i];
    if (!bank_c_i && idx_i == RegIdxDip) begin
      rdata_o = {24'h0, gpio_dip_sw_i};
    end
  end

  assign gpio_led_o = bank_f_q[RegIdxLed][7:0];

endmodule

// File: rtl/cmd_decoder_top.sv
// Ethernet-style command decoder: receives a 48-byte command frame, performs one
// register access and answers with a 48-byte acknowledge frame.
module cmd_decoder_top
  import cmd_decoder_pkg::*;
#(
  parameter logic [47:0] FPGA_MAC = 48'h5a0102030405
) (
  input  logic       gtx_tclk_i,
  input  logic       gtx_tresetn_i,
  input  logic       s_axi_aclk,
  input  logic       s_axi_resetn,
  input  logic       clk_fmc150,
  input  logic       resetn_fmc150,
  input  logic [7:0] gpio_dip_sw,
  output logic [7:0] gpio_led,
  input  logic [7:0] rx_axis_tdata,
  input  logic       rx_axis_tvalid,
  input  logic       rx_axis_tlast,
  output logic       rx_axis_tready,
  output logic [7:0] tx_axis_tdata,
  output logic       tx_axis_tvalid,
  output logic       tx_axis_tlast,
  input  logic       tx_axis_tready
);

  state_e      state_q, state_d;
  logic [5:0]  rx_cnt_q, rx_cnt_d;
  logic [5:0]  tx_cnt_q, tx_cnt_d;
  logic [7:0]  status_q, status_d;
  logic [31:0] out_data_q, out_data_d;
  logic [7:0]  rx_buf_q [BufLen];

  logic        rx_beat, tx_beat;
  logic        class_f, class_c, op_wr, op_rd, cmd_ok, reg_we;
  logic [3:0]  reg_idx;
  logic [31:0] wdata, rdata;
  logic [7:0]  mac_byte, tx_byte;
  logic [4:0]  buf_idx;
  logic        unused_reserved;

  assign unused_reserved = ^{s_axi_aclk, s_axi_resetn, clk_fmc150, resetn_fmc150};

  assign rx_axis_tready = !gtx_tresetn_i && (state_q == StRx || state_q == StDrain);
  assign rx_beat        = rx_axis_tvalid && rx_axis_tready;
  assign tx_axis_tvalid = (state_q == StTx);
  assign tx_beat        = tx_axis_tvalid && tx_axis_tready;
  assign tx_axis_tlast  = tx_axis_tvalid && (tx_cnt_q == FrameLast);
  assign tx_axis_tdata  = tx_axis_tvalid ? tx_byte : 8'h00;

  // Buffer offsets are frame offsets minus BufBase.
  assign class_f = (rx_buf_q[10] == ClassF) && (rx_buf_q[11] == ClassF);
  assign class_c = (rx_buf_q[10] == ClassC) && (rx_buf_q[11] == ClassC);
  assign op_wr   = (rx_buf_q[12] == OpWr) && (rx_buf_q[13] == OpWr);
  assign op_rd   = (rx_buf_q[12] == OpRd) && (rx_buf_q[13] == OpRd);
  assign cmd_ok  = (class_f || class_c) && (op_wr || op_rd);
  assign reg_idx = rx_buf_q[18][3:0];
  assign wdata   = {rx_buf_q[29], rx_buf_q[28], rx_buf_q[27], rx_buf_q[26]};
  assign reg_we  = (state_q == StExec) && cmd_ok && op_wr;
  assign buf_idx = 5'(rx_cnt_q - 6'(BufBase));

  cmd_regbank u_regbank (
    .gtx_tclk_i    (gtx_tclk_i),
    .gtx_tresetn_i (gtx_tresetn_i),
    .wr_en_i       (reg_we),
    .bank_c_i      (class_c),
    .idx_i         (reg_idx),
    .wdata_i       (wdata),
    .rdata_o       (rdata),
    .gpio_dip_sw_i (gpio_dip_sw),
    .gpio_led_o    (gpio_led)
  );

  always_comb begin
    mac_byte = 8'h00;
    for (int i = 0; i < 6; i++) begin
      if (rx_cnt_q == 6'(i)) mac_byte = FPGA_MAC[8*(5-i) +: 8];
    end
  end

  always_comb begin
    tx_byte = 8'h00;
    for (int i = 0; i < 6; i++) begin
      if (tx_cnt_q == 6'(i))     tx_byte = rx_buf_q[i];
      if (tx_cnt_q == 6'(6 + i)) tx_byte = FPGA_MAC[8*(5-i) +: 8];
    end
    if (tx_cnt_q == 6'd12) tx_byte = AckLenHi;
    if (tx_cnt_q == 6'd13) tx_byte = AckLenLo;
    if (tx_cnt_q == 6'd14) tx_byte = AckType;
    if (tx_cnt_q == 6'd15) tx_byte = status_q;
    for (int i = 16; i < 32; i++) begin
      if (tx_cnt_q == 6'(i)) tx_byte = rx_buf_q[i - BufBase];
    end
    for (int i = 0; i < 4; i++) begin
      if (tx_cnt_q == 6'(32 + i)) tx_byte = out_data_q[8*i +: 8];
    end
  end

  always_comb begin
    state_d    = state_q;
    rx_cnt_d   = rx_cnt_q;
    tx_cnt_d   = tx_cnt_q;
    status_d   = status_q;
    out_data_d = out_data_q;
    unique case (state_q)
      StRx: begin
        if (rx_beat) begin
          if (rx_cnt_q != FrameFull) rx_cnt_d = rx_cnt_q + 6'd1;
          // A destination mismatch is known early; discard the rest of the frame.
          if (rx_axis_tlast) begin
            state_d = StCheck;
          end else if (rx_cnt_q < 6'd6 && rx_axis_tdata != mac_byte) begin
            state_d = StDrain;
          end
        end
      end
      StCheck: begin
        rx_cnt_d = '0;
        tx_cnt_d = '0;
        state_d  = (rx_cnt_q == FrameFull) ? StExec : StRx;
      end
      StExec: begin
        status_d   = cmd_ok ? StatusOk : StatusErr;
        out_data_d = (cmd_ok && op_rd) ? rdata : wdata;
        state_d    = StTx;
      end
      StTx: begin
        if (tx_beat) begin
          if (tx_cnt_q == FrameLast) state_d = StRx;
          else                       tx_cnt_d = tx_cnt_q + 6'd1;
        end
      end
      StDrain: begin
        rx_cnt_d = '0;
        if (rx_beat && rx_axis_tlast) state_d = StRx;
      end
      default: state_d = StRx;
    endcase
  end

  always_ff @(posedge gtx_tclk_i or posedge gtx_tresetn_i) begin
    if (gtx_tresetn_i) begin
      state_q    <= StRx;
      rx_cnt_q   <= '0;
      tx_cnt_q   <= '0;
      status_q   <= '0;
      out_data_q <= '0;
      for (int i = 0; i < BufLen; i++) rx_buf_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      rx_cnt_q   <= rx_cnt_d;
      tx_cnt_q   <= tx_cnt_d;
      status_q   <= status_d;
      out_data_q <= out_data_d;
      if (state_q == StRx && rx_beat && rx_cnt_q >= 6'(BufBase)
          && rx_cnt_q < 6'(BufBase + BufLen)) begin
        rx_buf_q[buf_idx] <= rx_axis_tdata;
      end
    end
  end

endmodule

// File: tb/tb_cmd_decoder_top.sv
// Bench for cmd_decoder_top: a frame-level model predicts every ack byte and a
// negedge compare process checks the tx stream against it.
module tb_cmd_decoder_top;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] dip = 8'h3C;
  logic [7:0] gpio_led;
  logic [7:0] rx_tdata = '0;
  logic       rx_tvalid = 1'b0, rx_tlast = 1'b0, rx_tready;
  logic [7:0] tx_tdata;
  logic       tx_tvalid, tx_tlast;
  logic       tx_tready = 1'b1;

  int checks = 0;
  int errors = 0;

  logic [47:0] fpga_mac = 48'h5a0102030405;
  logic [47:0] src_mac  = 48'h112233445566;
  logic [7:0]  fr [64];
  logic [31:0] mf [16];
  logic [31:0] mc [16];
  logic [8:0]  exp_q [$];
  logic [7:0]  got_ack [48];
  int          ack_pos = 0;
  int          ack_done = 0;

  always #5 clk = ~clk;

  cmd_decoder_top dut (
    .gtx_tclk_i     (clk),
    .gtx_tresetn_i  (rst),
    .s_axi_aclk     (1'b0),
    .s_axi_resetn   (1'b0),
    .clk_fmc150     (1'b0),
    .resetn_fmc150  (1'b0),
    .gpio_dip_sw    (dip),
    .gpio_led       (gpio_led),
    .rx_axis_tdata  (rx_tdata),
    .rx_axis_tvalid (rx_tvalid),
    .rx_axis_tlast  (rx_tlast),
    .rx_axis_tready (rx_tready),
    .tx_axis_tdata  (tx_tdata),
    .tx_axis_tvalid (tx_tvalid),
    .tx_axis_tlast  (tx_tlast),
    .tx_axis_tready (tx_tready)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h", name, got, want);
    end
  endtask

  // Every cycle with tvalid high must show the model's next ack byte.
  always @(negedge clk) begin
    if (!rst && tx_tvalid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL tx_unexpected: tvalid=1 tdata=%02h with no ack pending", tx_tdata);
      end else begin
        if (tx_tdata !== exp_q[0][7:0] || tx_tlast !== exp_q[0][8]) begin
          errors++;
          $display("FAIL tx_byte[%0d]: got %02h last %0b, want %02h last %0b", ack_pos,
                   tx_tdata, tx_tlast, exp_q[0][7:0], exp_q[0][8]);
        end
        if (tx_tready) begin
          if (ack_pos < 48) got_ack[ack_pos] = tx_tdata;
          if (exp_q[0][8]) begin
            ack_pos = 0;
            ack_done++;
          end else begin
            ack_pos++;
          end
          void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic build(input logic [47:0] dst, input logic [15:0] cls, input logic [15:0] op,
                       input logic [31:0] id, input logic [31:0] addr, input logic [31:0] data);
    for (int i = 0; i < 64; i++) fr[i] = 8'(i) ^ 8'hA5;
    for (int i = 0; i < 6; i++) begin
      fr[i]     = dst[8*(5-i) +: 8];
      fr[6 + i] = src_mac[8*(5-i) +: 8];
    end
    fr[12] = 8'h00; fr[13] = 8'h30; fr[14] = 8'h00; fr[15] = 8'h00;
    fr[16] = cls[7:0]; fr[17] = cls[15:8]; fr[18] = op[7:0]; fr[19] = op[15:8];
    for (int i = 0; i < 4; i++) begin
      fr[20 + i] = id[8*i +: 8];
      fr[24 + i] = addr[8*i +: 8];
      fr[28 + i] = (i == 0) ? 8'h01 : 8'h00;
      fr[32 + i] = data[8*i +: 8];
    end
  endtask

  // Frame-level model: decide accept/drop, apply the access, queue the ack.
  task automatic model_frame(input int nbytes);
    logic [47:0] dst;
    logic        bf, bc, wr, rd, ok;
    logic [3:0]  idx;
    logic [31:0] wd, rv;
    logic [7:0]  ack [48];
    for (int i = 0; i < 6; i++) dst[8*(5-i) +: 8] = fr[i];
    if (dst != fpga_mac || nbytes < 48) return;
    bf  = fr[16] == 8'h46 && fr[17] == 8'h46;
    bc  = fr[16] == 8'h43 && fr[17] == 8'h43;
    wr  = fr[18] == 8'h57 && fr[19] == 8'h57;
    rd  = fr[18] == 8'h52 && fr[19] == 8'h52;
    ok  = (bf || bc) && (wr || rd);
    idx = fr[24][3:0];
    wd  = {fr[35], fr[34], fr[33], fr[32]};
    rv  = wd;
    if (ok && wr) begin
      if (bc) mc[idx] = wd;
      else if (idx != 4'd1) mf[idx] = wd;
    end
    if (ok && rd) rv = bc ? mc[idx] : ((idx == 4'd1) ? {24'h0, dip} : mf[idx]);
    for (int i = 0; i < 48; i++) ack[i] = 8'h00;
    for (int i = 0; i < 6; i++) begin
      ack[i]     = fr[6 + i];
      ack[6 + i] = fpga_mac[8*(5-i) +: 8];
    end
    ack[13] = 8'h22;
    ack[14] = 8'h01;
    ack[15] = ok ? 8'h00 : 8'hEE;
    for (int i = 16; i < 32; i++) ack[i] = fr[i];
    for (int i = 0; i < 4; i++) ack[32 + i] = rv[8*i +: 8];
    for (int i = 0; i < 48; i++) exp_q.push_back({(i == 47), ack[i]});
  endtask

  task automatic send_byte(input logic [7:0] b, input logic last);
    logic ok;
    int   n;
    n = 0;
    rx_tdata = b; rx_tvalid = 1'b1; rx_tlast = last;
    do begin
      @(negedge clk); ok = rx_tready;
      @(posedge clk); #1; n++;
    end while (!ok && n < 2000);
    if (!ok) begin
      checks++; errors++;
      $display("FAIL rx_ready_timeout: got tready=0 for %0d cycles, want 1", n);
    end
  endtask

  task automatic send_frame(input int nbytes, input logic want_ack);
    int n;
    model_frame(nbytes);
    chk("model_accept", 32'(exp_q.size() != 0), 32'(want_ack));
    for (int i = 0; i < nbytes; i++) send_byte(fr[i], i == nbytes - 1);
    rx_tvalid = 1'b0; rx_tlast = 1'b0;
    if (want_ack) begin
      n = 0;
      while (!tx_tvalid && n < 10) begin @(posedge clk); #1; n++; end
      chk("ack_latency_le3", 32'(n <= 3), 32'd1);
    end
  endtask

  task automatic wait_ack(input logic toggle);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      if (toggle) tx_tready = 1'($urandom_range(0, 1));
      @(posedge clk); #1; n++;
    end
    tx_tready = 1'b1;
    chk("ack_drained", 32'(exp_q.size()), 32'd0);
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    rx_tvalid = 1'b0; rx_tlast = 1'b0;
    @(negedge clk);
    chk("rst_rx_tready", 32'(rx_tready), 32'd0);
    chk("rst_tx_tvalid", 32'(tx_tvalid), 32'd0);
    chk("rst_tx_tlast", 32'(tx_tlast), 32'd0);
    chk("rst_tx_tdata", 32'(tx_tdata), 32'd0);
    chk("rst_gpio_led", 32'(gpio_led), 32'd0);
    exp_q.delete();
    ack_pos = 0;
    for (int i = 0; i < 16; i++) begin mf[i] = '0; mc[i] = '0; end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rx_tready_after_reset", 32'(rx_tready), 32'd1);
    @(posedge clk); #1;
  endtask

  initial begin
    int acks0;
    do_reset();

    // Write F[14] = 0x77 through address 0x1e.
    build(fpga_mac, 16'h4646, 16'h5757, 32'h17fc, 32'h1e, 32'h77);
    send_frame(48, 1'b1);
    wait_ack(1'b0);
    chk("wr_status", 32'(got_ack[15]), 32'h00);
    chk("wr_echo_data", {got_ack[35], got_ack[34], got_ack[33], got_ack[32]}, 32'h77);
    chk("wr_echo_id", {got_ack[23], got_ack[22], got_ack[21], got_ack[20]}, 32'h17fc);
    chk("ack_len_byte13", 32'(got_ack[13]), 32'h22);
    build(fpga_mac, 16'h4646, 16'h5252, 32'h17fd, 32'h0e, 32'h0);
    send_frame(48, 1'b1);
    wait_ack(1'b1);
    chk("rd_f14", {got_ack[35], got_ack[34], got_ack[33], got_ack[32]}, 32'h77);

    // LED write then DIP read.
    build(fpga_mac, 16'h4646, 16'h5757, 32'h20, 32'h0, 32'h5a);
    send_frame(48, 1'b1);
    wait_ack(1'b0);
    chk("gpio_led_5a", 32'(gpio_led), 32'h5a);
    dip = 8'hFF;
    build(fpga_mac, 16'h4646, 16'h5252, 32'h21, 32'h1, 32'h0);
    send_frame(48, 1'b1);
    wait_ack(1'b0);
    chk("rd_dip", {got_ack[35], got_ack[34], got_ack[33], got_ack[32]}, 32'h0000_00ff);
    // F[1] is read-only: the write must leave the DIP view in place.
    build(fpga_mac, 16'h4646, 16'h5757, 32'h22, 32'h1, 32'h1234);
    send_frame(48, 1'b1);
    wait_ack(1'b0);
    build(fpga_mac, 16'h4646, 16'h5252, 32'h23, 32'h1, 32'h0);
    send_frame(48, 1'b1);
    wait_ack(1'b0);
    chk("rd_dip_after_wr", 32'(got_ack[32]), 32'hff);

    // Wrong destination MAC: dropped silently, LED unchanged.
    acks0 = ack_done;
    build(48'h5a0102030406, 16'h4646, 16'h5757, 32'h30, 32'h0, 32'h99);
    send_frame(48, 1'b0);
    repeat (20) @(posedge clk);
    #1;
    chk("mac_drop_no_ack", 32'(ack_done - acks0), 32'd0);
    chk("mac_drop_led", 32'(gpio_led), 32'h5a);

    // Unknown class / unknown op.
    build(fpga_mac, 16'h4747, 16'h5757, 32'h31, 32'h0, 32'h11);
    send_frame(48, 1'b1);
    wait_ack(1'b0);
    chk("bad_class_status", 32'(got_ack[15]), 32'hee);
    chk("bad_class_led", 32'(gpio_led), 32'h5a);
    build(fpga_mac, 16'h4343, 16'h5858, 32'h32, 32'h3, 32'h11);
    send_frame(48, 1'b1);
    wait_ack(1'b0);
    chk("bad_op_status", 32'(got_ack[15]), 32'hee);

    // Short frame dropped; long frame to bank C accepted.
    build(fpga_mac, 16'h4343, 16'h5757, 32'h33, 32'h3, 32'hdead);
    send_frame(40, 1'b0);
    repeat (10) @(posedge clk);
    #1;
    build(fpga_mac, 16'h4343, 16'h5757, 32'h34, 32'h5, 32'hcafe_0001);
    send_frame(60, 1'b1);
    wait_ack(1'b1);
    build(fpga_mac, 16'h4343, 16'h5252, 32'h35, 32'h5, 32'h0);
    send_frame(48, 1'b1);
    wait_ack(1'b0);
    chk("rd_c5", {got_ack[35], got_ack[34], got_ack[33], got_ack[32]}, 32'hcafe_0001);
    build(fpga_mac, 16'h4343, 16'h5252, 32'h36, 32'h3, 32'h0);
    send_frame(48, 1'b1);
    wait_ack(1'b0);
    chk("rd_c3_untouched", {got_ack[35], got_ack[34], got_ack[33], got_ack[32]}, 32'h0);

    // Stalled ack: tready low for 32 cycles after the frame.
    do_reset();
    tx_tready = 1'b0;
    build(fpga_mac, 16'h4646, 16'h5757, 32'h40, 32'h2, 32'h55);
    send_frame(48, 1'b1);
    repeat (32) @(posedge clk);
    #1;
    chk("stall_tvalid", 32'(tx_tvalid), 32'd1);
    chk("stall_tdata_held", 32'(tx_tdata), 32'h11);
    tx_tready = 1'b1;
    wait_ack(1'b0);

    // Back-to-back frames every 256 cycles.
    for (int k = 0; k < 4; k++) begin
      acks0 = ack_done;
      build(fpga_mac, 16'h4646, 16'h5757, 32'h0a00 + 32'(k), 32'h3, 32'(k));
      fork
        begin
          send_frame(48, 1'b1);
          wait_ack(1'b0);
        end
        begin
          repeat (256) @(posedge clk);
        end
      join
      #1;
      chk("b2b_one_ack", 32'(ack_done - acks0), 32'd1);
      chk("b2b_id", {got_ack[23], got_ack[22], got_ack[21], got_ack[20]}, 32'h0a00 + 32'(k));
    end

    // Reset mid-ack, then mid-frame; both must abort cleanly.
    tx_tready = 1'b0;
    build(fpga_mac, 16'h4646, 16'h5757, 32'h50, 32'h0, 32'h3c);
    send_frame(48, 1'b1);
    repeat (5) @(posedge clk);
    #1;
    tx_tready = 1'b1;
    do_reset();
    build(fpga_mac, 16'h4646, 16'h5757, 32'h51, 32'h0, 32'h3c);
    for (int i = 0; i < 20; i++) send_byte(fr[i], 1'b0);
    do_reset();
    build(fpga_mac, 16'h4646, 16'h5252, 32'h52, 32'h0, 32'h0);
    send_frame(48, 1'b1);
    wait_ack(1'b0);
    chk("rd_f0_after_reset", {got_ack[35], got_ack[34], got_ack[33], got_ack[32]}, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cmd_decoder_top.md
CMD_DECODER_TOP -- requirements
Module: cmd_decoder_top

Interface
REQ-001 SHALL have parameter FPGA_MAC, default 48'h5a0102030405, the local MAC address that frames must match.
REQ-002 SHALL have port gtx_tclk_i, input, 1 bit: the single clock for all logic; reset gtx_tresetn_i, asynchronous, active-high; clock gtx_tclk_i.
REQ-003 SHALL have port gtx_tresetn_i, input, 1 bit: asynchronous active-high reset.
REQ-004 SHALL have ports s_axi_aclk, s_axi_resetn, clk_fmc150 and resetn_fmc150, all inputs, 1 bit each: reserved, with no logic attached.
REQ-005 SHALL have port gpio_dip_sw, input, 8 bits: switch state, readable via the register bank.
REQ-006 SHALL have port gpio_led, output, 8 bits: driven from the LED register.
REQ-007 SHALL have ports rx_axis_tdata (input, 8), rx_axis_tvalid (input, 1), rx_axis_tlast (input, 1) and rx_axis_tready (output, 1): the command frame input stream.
REQ-008 SHALL have ports tx_axis_tdata (output, 8), tx_axis_tvalid (output, 1), tx_axis_tlast (output, 1) and tx_axis_tready (input, 1): the acknowledge frame output stream.

Function
REQ-009 A byte transfers when tvalid and tready are both high on a rising edge of gtx_tclk_i; multi-byte numeric fields are little-endian.
REQ-010 Receive frame layout (byte offsets):
- 0-5: destination MAC, big-endian
- 6-11: source MAC
- 12-13: length
- 14-15: flags
- 16-17: class, 0x4646 'FF' = bank F, 0x4343 'CC' = bank C
- 18-19: op, 0x5757 'WW' = write, 0x5252 'RR' = read
- 20-23: command ID
- 24-27: address
- 28-31: count
- 32-35: write data
- 36-47: don't care
REQ-011 The FSM states SHALL be RX, CHECK, EXEC, TX and DRAIN.
- RX: tready=1, bytes are captured.
- The beat with tlast moves RX to CHECK.
REQ-012 Any of the following SHALL drop the frame silently (return to RX, no ack, no register change):
- destination MAC != FPGA_MAC
- tlast before byte 47
REQ-013 Bytes after byte 47 SHALL be ignored until tlast; the command is still processed.
REQ-014 A frame with tlast but missing more than 47 bytes is covered by REQ-012.
REQ-015 EXEC SHALL perform one register access:
- two banks (F, C) of 16 x 32-bit registers each, index = address[3:0]
- write stores the write data
- read latches the register value
REQ-016 Read-only register: F bank index 1 reads {24'h0, gpio_dip_sw}; writes to it are ignored.
REQ-017 gpio_led SHALL equal bank F register 0 bits [7:0].
REQ-018 An unknown class or op SHALL perform no access and SHALL set status 0xEE; a successful access sets status 0x00.
REQ-019 TX SHALL emit exactly 48 bytes with tlast on byte 47; the ack frame layout is:
- 0-5: received source MAC
- 6-11: FPGA_MAC
- 12-13: 0x00,0x22
- 14: 0x01
- 15: status
- 16-31: echo of received bytes 16-31
- 32-35: read data for a read, echo of write data otherwise
- 36-47: 0x00
REQ-020 tx_axis_tdata, tx_axis_tvalid and tx_axis_tlast SHALL be held stable while tvalid=1 and tready=0.
REQ-021 The first ack byte SHALL be valid no later than 3 cycles after the rx tlast beat.
REQ-022 rx_axis_tready SHALL be 0 in CHECK, EXEC and TX; after the final TX beat the FSM returns to RX.
REQ-023 DRAIN: tready=1, bytes are discarded until tlast, then the FSM returns to RX.

Reset
REQ-024 While gtx_tresetn_i is high:
- FSM in RX, rx_axis_tready=0
- tx_axis_tvalid=0, tx_axis_tlast=0, tx_axis_tdata=0
- all registers 0, gpio_led=0
REQ-025 rx_axis_tready SHALL be 1 from the first clock after reset deasserts.
REQ-026 Reset asserted mid-frame or mid-ack SHALL abort immediately.

Structure
REQ-027 A shared package SHALL hold: class/op constants (0x46, 0x43, 0x57, 0x52), status codes, frame length 48, ack header constants and the FSM state enum.
REQ-028 One sub-module, cmd_regbank, SHALL hold both banks, the DIP read-only mux and the LED output.

Verification
REQ-029 FF/WW frame, ID 0x17fc, address 0x1e, data 0x77 -> bank F register 14 = 0x77; ack byte 15 = 0x00; ack bytes 32-35 = 77 00 00 00; tlast on byte 47.
REQ-030 FF/WW to address 0 with data 0x5A, then FF/RR to address 1 with gpio_dip_sw=0xFF -> gpio_led=0x5A; ack read data = FF 00 00 00.
REQ-031 Destination MAC 5a0102030406 -> no tx_axis_tvalid; registers unchanged.
REQ-032 Class 0x4747 -> ack status 0xEE; no register change.
REQ-033 tx_axis_tready low for 32 cycles after reset, with a frame arriving -> ack stalls with tdata held, then completes all 48 bytes in order.
REQ-034 Back-to-back frames every 256 cycles with incrementing ID -> one ack per frame, each echoing its ID.
